// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared definitions for the DA sample path
//
// Purpose: sample width, pacer FSM encoding and FIFO pointer-width helper,
// shared by da_sample_feeder, da_sync_fifo and DA_block.
// Ports: none (package).

package da_pkg;

  localparam int DW = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One extra pointer bit distinguishes full from empty when the
  // address bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/da_sync_fifo.sv
// rtl/da_sync_fifo.sv - single-clock circular-buffer FIFO
//
// Purpose: DEPTH-entry FIFO with registered pointers and a
// combinational (show-ahead) head read.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, wdata      write request and data (ignored while full)
//   pop              read request (ignored while empty)
//   rdata            current head entry
//   full, empty      occupancy flags, decoded from the pointers
//   level            current number of stored entries

module da_sync_fifo
  import da_pkg::*;
#(
  parameter int DW    = da_pkg::DW,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DW-1:0]             wdata,
  output logic [DW-1:0]             rdata,
  output logic                      full,
  output logic                      empty,
  output logic [ptr_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;

endmodule

// File: rtl/da_sample_feeder.sv
// rtl/da_sample_feeder.sv - paced sample source feeding DA_block
//
// Purpose: buffers producer samples in a FIFO and emits one sample on din
// with a single-cycle we strobe every RATE_DIV cycles while enabled.
// Ports:
//   dack, reset_n          clock, asynchronous active-low reset
//   enable                 1 = pacer runs, 0 = pacer idle
//   in_valid, in_data      producer sample handshake
//   in_ready               FIFO not full (combinational from pointers)
//   we, din                registered strobe and sample to DA_block
//   level                  FIFO occupancy
//   underrun, clr_underrun sticky empty-slot flag and its clear

module da_sample_feeder
  import da_pkg::*;
#(
  parameter int DW       = da_pkg::DW,
  parameter int DEPTH    = 16,
  parameter int RATE_DIV = 4
) (
  input  logic                    dack,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [DW-1:0]           in_data,
  output logic                    in_ready,
  output logic                    we,
  output logic [DW-1:0]           din,
  output logic [ptr_w(DEPTH)-1:0] level,
  output logic                    underrun,
  input  logic                    clr_underrun
);

  localparam int              CW   = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(RATE_DIV - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          slot;

  logic          fifo_push;
  logic          fifo_pop;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;

  always_ff @(posedge dack or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Dropping enable suppresses a slot in the same cycle and zeroes the
  // counter, so a re-enable always waits a full RATE_DIV period.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    slot      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          slot    = (cnt == LAST);
          cnt_nxt = slot ? '0 : cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  // empty reflects registered pointers, so a same-cycle push cannot
  // satisfy this slot.
  assign fifo_pop  = slot && !fifo_empty;

  da_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (dack),
    .rst_n (reset_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge dack or negedge reset_n) begin
    if (!reset_n) begin
      we       <= 1'b0;
      din      <= '0;
      underrun <= 1'b0;
    end else begin
      we <= fifo_pop;
      if (fifo_pop) din <= fifo_rdata;
      // A new underrun takes priority over a clear in the same cycle.
      if (slot && fifo_empty) underrun <= 1'b1;
      else if (clr_underrun)  underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_da_sample_feeder.sv
// tb/tb_da_sample_feeder.sv - directed self-checking bench for da_sample_feeder

module tb_da_sample_feeder;

  logic dack;
  logic rst_n;

  // instance A: RATE_DIV=4
  logic       a_en, a_iv, a_ir, a_we, a_ur, a_clr;
  logic [7:0] a_id, a_din;
  logic [4:0] a_lvl;
  // instance B: RATE_DIV=1
  logic       b_en, b_iv, b_ir, b_we, b_ur, b_clr;
  logic [7:0] b_id, b_din;
  logic [4:0] b_lvl;
  // instance C: RATE_DIV=2
  logic       c_en, c_iv, c_ir, c_we, c_ur, c_clr;
  logic [7:0] c_id, c_din;
  logic [4:0] c_lvl;

  int checks = 0;
  int fails  = 0;

  da_sample_feeder #(.DW(8), .DEPTH(16), .RATE_DIV(4)) dut_a (
    .dack(dack), .reset_n(rst_n), .enable(a_en), .in_valid(a_iv), .in_data(a_id),
    .in_ready(a_ir), .we(a_we), .din(a_din), .level(a_lvl), .underrun(a_ur),
    .clr_underrun(a_clr));

  da_sample_feeder #(.DW(8), .DEPTH(16), .RATE_DIV(1)) dut_b (
    .dack(dack), .reset_n(rst_n), .enable(b_en), .in_valid(b_iv), .in_data(b_id),
    .in_ready(b_ir), .we(b_we), .din(b_din), .level(b_lvl), .underrun(b_ur),
    .clr_underrun(b_clr));

  da_sample_feeder #(.DW(8), .DEPTH(16), .RATE_DIV(2)) dut_c (
    .dack(dack), .reset_n(rst_n), .enable(c_en), .in_valid(c_iv), .in_data(c_id),
    .in_ready(c_ir), .we(c_we), .din(c_din), .level(c_lvl), .underrun(c_ur),
    .clr_underrun(c_clr));

  initial dack = 1'b0;
  always #5 dack = ~dack;

  task automatic tick;
    @(posedge dack);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    a_iv = 1'b1;
    a_id = d;
    tick();
    a_iv = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (a_we !== 1'b0)  begin fails++; $display("FAIL reset_we: got %0b want 0", a_we); end
    checks++; if (a_din !== 8'd0) begin fails++; $display("FAIL reset_din: got %0d want 0", a_din); end
    checks++; if (a_lvl !== 5'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", a_lvl); end
    checks++; if (a_ir !== 1'b1)  begin fails++; $display("FAIL reset_in_ready: got %0b want 1", a_ir); end
    checks++; if (a_ur !== 1'b0)  begin fails++; $display("FAIL reset_underrun: got %0b want 0", a_ur); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (a_lvl !== 5'd0 || a_ir !== 1'b1 || a_we !== 1'b0) begin
      fails++; $display("FAIL reset_release: level %0d ready %0b we %0b want 0 1 0", a_lvl, a_ir, a_we);
    end
  endtask

  task automatic test_playback;
    logic       exp_we;
    logic [7:0] exp_din;
    push_a(8'd1);
    push_a(8'd2);
    push_a(8'd3);
    checks++; if (a_lvl !== 5'd3) begin fails++; $display("FAIL play_level_pre: got %0d want 3", a_lvl); end
    a_en = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      tick();
      exp_we  = (k == 4 || k == 8 || k == 12);
      exp_din = (k < 4) ? 8'd0 : (k < 8) ? 8'd1 : (k < 12) ? 8'd2 : 8'd3;
      checks++; if (a_we !== exp_we) begin
        fails++; $display("FAIL play_we[%0d]: got %0b want %0b", k, a_we, exp_we);
      end
      checks++; if (a_din !== exp_din) begin
        fails++; $display("FAIL play_din[%0d]: got %0d want %0d", k, a_din, exp_din);
      end
    end
    checks++; if (a_lvl !== 5'd0 || a_ur !== 1'b0) begin
      fails++; $display("FAIL play_post: level %0d underrun %0b want 0 0", a_lvl, a_ur);
    end
    a_en = 1'b0;
    tick();
  endtask

  task automatic test_collision;
    push_a(8'd10);
    checks++; if (a_lvl !== 5'd1) begin fails++; $display("FAIL coll_level_pre: got %0d want 1", a_lvl); end
    a_en = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      tick();
      checks++; if (a_we !== 1'b0) begin fails++; $display("FAIL coll_we_early[%0d]: got %0b want 0", k, a_we); end
    end
    a_iv = 1'b1;
    a_id = 8'd11;
    tick();
    a_iv = 1'b0;
    checks++; if (a_we !== 1'b1 || a_din !== 8'd10) begin
      fails++; $display("FAIL coll_first: we %0b din %0d want 1 10", a_we, a_din);
    end
    checks++; if (a_lvl !== 5'd1) begin fails++; $display("FAIL coll_level: got %0d want 1", a_lvl); end
    for (int k = 5; k <= 8; k++) begin
      tick();
      checks++; if (a_we !== (k == 8)) begin
        fails++; $display("FAIL coll_we[%0d]: got %0b want %0b", k, a_we, (k == 8));
      end
    end
    checks++; if (a_din !== 8'd11 || a_lvl !== 5'd0) begin
      fails++; $display("FAIL coll_second: din %0d level %0d want 11 0", a_din, a_lvl);
    end
    a_en = 1'b0;
    tick();
  endtask

  task automatic test_enable_toggle;
    push_a(8'd20);
    push_a(8'd21);
    a_en = 1'b1;
    tick();
    tick();
    tick();
    a_en = 1'b0;
    tick();
    tick();
    checks++; if (a_we !== 1'b0 || a_lvl !== 5'd2 || a_din !== 8'd11) begin
      fails++; $display("FAIL toggle_no_slot: we %0b level %0d din %0d want 0 2 11", a_we, a_lvl, a_din);
    end
    a_en = 1'b1;
    for (int j = 0; j <= 4; j++) begin
      tick();
      checks++; if (a_we !== (j == 4)) begin
        fails++; $display("FAIL toggle_we[%0d]: got %0b want %0b", j, a_we, (j == 4));
      end
    end
    checks++; if (a_din !== 8'd20 || a_lvl !== 5'd1) begin
      fails++; $display("FAIL toggle_out: din %0d level %0d want 20 1", a_din, a_lvl);
    end
    a_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) push_a(8'(30 + i));
    checks++; if (a_lvl !== 5'd5) begin fails++; $display("FAIL rstmid_level_pre: got %0d want 5", a_lvl); end
    a_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (a_lvl !== 5'd0 || a_ir !== 1'b1) begin
      fails++; $display("FAIL rstmid_fifo: level %0d ready %0b want 0 1", a_lvl, a_ir);
    end
    checks++; if (a_we !== 1'b0 || a_din !== 8'd0 || a_ur !== 1'b0) begin
      fails++; $display("FAIL rstmid_outs: we %0b din %0d underrun %0b want 0 0 0", a_we, a_din, a_ur);
    end
    a_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (a_lvl !== 5'd0 || a_din !== 8'd0) begin
      fails++; $display("FAIL rstmid_release: level %0d din %0d want 0 0", a_lvl, a_din);
    end
  endtask

  task automatic test_backpressure;
    int   v, got, gaps;
    logic acc, started;
    v = 0; got = 0; gaps = 0; started = 1'b0;
    for (int c = 0; c < 18; c++) begin
      b_iv = 1'b1;
      b_id = 8'(v);
      acc  = b_ir;
      tick();
      if (acc) v++;
    end
    checks++; if (v != 16) begin fails++; $display("FAIL bp_accepted: got %0d want 16", v); end
    checks++; if (b_lvl !== 5'd16 || b_ir !== 1'b0) begin
      fails++; $display("FAIL bp_full: level %0d ready %0b want 16 0", b_lvl, b_ir);
    end
    b_en = 1'b1;
    for (int c = 0; c < 60 && got < 20; c++) begin
      b_iv = (v < 20);
      b_id = 8'(v);
      acc  = b_iv && b_ir;
      tick();
      if (acc) v++;
      if (b_we) begin
        started = 1'b1;
        checks++; if (b_din !== 8'(got)) begin
          fails++; $display("FAIL bp_order[%0d]: got %0d want %0d", got, b_din, got);
        end
        got++;
      end else if (started) begin
        gaps++;
      end
    end
    b_iv = 1'b0;
    b_en = 1'b0;
    checks++; if (got != 20 || v != 20) begin
      fails++; $display("FAIL bp_count: out %0d in %0d want 20 20", got, v);
    end
    checks++; if (gaps != 0) begin fails++; $display("FAIL bp_gaps: got %0d want 0", gaps); end
    checks++; if (b_lvl !== 5'd0 || b_ur !== 1'b0) begin
      fails++; $display("FAIL bp_end: level %0d underrun %0b want 0 0", b_lvl, b_ur);
    end
    tick();
  endtask

  task automatic test_underrun;
    c_en = 1'b1;
    tick();
    tick();
    checks++; if (c_ur !== 1'b0) begin fails++; $display("FAIL ur_before: got %0b want 0", c_ur); end
    tick();
    checks++; if (c_ur !== 1'b1 || c_we !== 1'b0) begin
      fails++; $display("FAIL ur_set: underrun %0b we %0b want 1 0", c_ur, c_we);
    end
    tick();
    c_clr = 1'b1;
    tick();
    checks++; if (c_ur !== 1'b1) begin fails++; $display("FAIL ur_set_wins: got %0b want 1", c_ur); end
    tick();
    c_clr = 1'b0;
    checks++; if (c_ur !== 1'b0) begin fails++; $display("FAIL ur_clear: got %0b want 0", c_ur); end
    tick();
    checks++; if (c_ur !== 1'b1 || c_we !== 1'b0 || c_din !== 8'd0) begin
      fails++; $display("FAIL ur_reset_again: underrun %0b we %0b din %0d want 1 0 0", c_ur, c_we, c_din);
    end
    c_en = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b0; a_iv = 1'b0; a_id = 8'd0; a_clr = 1'b0;
    b_en = 1'b0; b_iv = 1'b0; b_id = 8'd0; b_clr = 1'b0;
    c_en = 1'b0; c_iv = 1'b0; c_id = 8'd0; c_clr = 1'b0;
    test_reset();
    test_playback();
    test_collision();
    test_enable_toggle();
    test_reset_mid();
    test_backpressure();
    test_underrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/da_sample_feeder.md
# da_sample_feeder

Paced sample source for `DA_block`. It accepts 8-bit samples from an upstream producer through a valid/ready handshake and buffers them in a small FIFO. It presents one sample at a time on `din` with a single-cycle `we` strobe at a programmable rate. It replaces bench-driven `din`/`we` stimulus with a synthesizable stage placed directly upstream of `DA_block`.

## Interface
- `DW`, 8, sample width (matches `DA_block` `din`)
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `RATE_DIV`, 4, `dack` cycles per output slot; ≥ 1
- `dack`  in  1  clock (shared with `DA_block`)
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  1 = pacer runs, 0 = pacer idle
- `in_valid`  in  1  producer has a sample
- `in_data`  in  DW  producer sample
- `in_ready`  out  1  FIFO can accept; equals !full
- `we`  out  1  one-cycle write strobe to `DA_block`
- `din`  out  DW  sample to `DA_block`; held between strobes
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `underrun`  out  1  sticky: slot occurred with FIFO empty
- `clr_underrun`  in  1  synchronous clear of `underrun`

## Operation
- **Push:** when `in_valid && in_ready`, `in_data` is written at the tail. `level` increments unless a pop happens in the same cycle.
- **FIFO storage:** circular buffer with `DEPTH` entries. Read and write pointers are $clog2(DEPTH)+1 bits wide, with the extra bit used for full/empty detection; they wrap modulo 2·`DEPTH`.
- **FSM states:**
  - IDLE: `enable`=0; pacer counter held at 0; `we`=0.
  - RUN: pacer counter counts 0…`RATE_DIV`-1 and wraps.
  - Transitions: IDLE→RUN on `enable`=1. RUN→IDLE on `enable`=0, which zeroes the counter immediately. The FIFO contents are kept.
- **Slot:** occurs in RUN when counter == `RATE_DIV`-1.
  - FIFO non-empty at the slot: pop head. Register `din` ← head and `we` ← 1 for exactly one cycle.
  - FIFO empty at the slot: `we` ← 0, `din` unchanged, `underrun` ← 1.
- **Push into empty FIFO:** a push in the same cycle as a slot is not visible to that slot. There is no bypass path.
- **Simultaneous push and pop** in one cycle: both take effect and `level` is unchanged.
- **Full FIFO:** `in_ready`=0, so no push can occur. `in_ready` recovers in the cycle after a pop.
- **Underrun flag:** `clr_underrun` clears it. If a clear and a new underrun occur in the same cycle, set wins.
- **`RATE_DIV`=1:** every RUN cycle is a slot, giving back-to-back `we` while data is available.

## Timing
- **Reset values:** `we`=0, `din`=0, `level`=0, `in_ready`=1, `underrun`=0. Also FSM=IDLE, counter=0, pointers=0.
- **Reset mid-operation:** asynchronous assertion clears the FIFO and all outputs at once. Buffered samples are discarded.
- **Output registering:** `we` and `din` are registered and change only on `dack` rising edges.
- **Latency:** a sample pushed at edge t into an empty FIFO, in RUN, appears at the first slot at or after t+1. `din`/`we` update at the edge ending that slot cycle.
- **Startup:** after `enable` rises, the first slot is `RATE_DIV` cycles later.
- **Strobe rate:** with a continuously non-empty FIFO, `we` pulses exactly every `RATE_DIV` cycles.
- **Combinational output:** `in_ready` is the only combinational output, decoded from the pointers and not from `in_valid`.

## Structure
- **Shared package `da_pkg`:** holds `DW`=8, the FSM state encoding (IDLE, RUN), and the pointer-width function. It is shared with `DA_block`.
- **Sub-module `da_sync_fifo`** (parameters `DW`, `DEPTH`; ports push, pop, data in/out, full, empty, level). The parent module holds the pacer, FSM, output registers and underrun flag.

## Test plan
- **Reset:** hold `reset_n`=0 mid-run with 5 samples buffered, then release → all outputs at reset values, `level`=0, `in_ready`=1.
- **Paced playback:** `RATE_DIV`=4; push 1,2,3 back-to-back; set `enable`=1 → `we` pulses at cycles 4, 8 and 12 after enable, with `din` = 1, 2, 3, and `din` stays 3 afterwards.
- **Full/backpressure:** `enable`=0; offer 20 samples (0…19) → `in_ready` drops after 16 are accepted and `level`=16. Enable with `RATE_DIV`=1 → the remaining 4 are accepted, and `din` plays out 0…19 in order with no gaps.
- **Underrun:** `enable`=1, `RATE_DIV`=2, FIFO empty → no `we` and `underrun`=1. Pulse `clr_underrun` in the same cycle as the next empty slot → `underrun` stays 1.
- **Push/pop collision:** `level`=1 with a push coinciding with the slot → `level` stays 1 and output order is preserved.
- **Enable toggle:** drop `enable` one cycle before a slot → no `we`, counter resets. Re-enable → next `we` exactly `RATE_DIV` cycles later.
